// File: rtl/vc_wrr_scheduler.sv
// Weighted round-robin drain of virtual-channel FIFOs VC0/VC1 into destination FIFOs D0/D1.
// Pops are combinational from state; the popped word is steered by its destination bit two cycles later.
module vc_wrr_scheduler #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = 4,
  parameter int WEIGHT_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 active,
  input  logic [WEIGHT_W-1:0]  weight_vc0,
  input  logic [WEIGHT_W-1:0]  weight_vc1,
  input  logic                 fifo_empty_vc0,
  input  logic                 fifo_empty_vc1,
  input  logic                 fifo_pause_d0,
  input  logic                 fifo_pause_d1,
  input  logic [DATA_SIZE-1:0] data_mux_0,
  input  logic [DATA_SIZE-1:0] data_mux_1,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_d0,
  output logic [DATA_SIZE-1:0] data_d1,
  output logic [1:0]           grant
);

  // One-hot encoding lets the state register drive grant directly.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SERVE_VC0 = 2'b01,
    SERVE_VC1 = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [WEIGHT_W-1:0]   cnt_q, cnt_d;
  logic [WEIGHT_W-1:0]   cnt_inc;
  logic [WEIGHT_W-1:0]   wt0_q, wt0_d;
  logic [WEIGHT_W-1:0]   wt1_q, wt1_d;
  logic                  last_q, last_d;
  logic                  pop_q, pop_d;
  logic                  src_q, src_d;
  logic                  push_d0_q, push_d0_d;
  logic                  push_d1_q, push_d1_d;
  logic [DATA_SIZE-1:0]  data_d0_q, data_d0_d;
  logic [DATA_SIZE-1:0]  data_d1_q, data_d1_d;
  logic [DATA_SIZE-1:0]  rd_word;
  logic                  elig0, elig1;
  logic                  pop0, pop1;

  // Either pause blocks both VCs: the destination is unknown until the word is read.
  assign elig0   = active & ~fifo_empty_vc0 & ~fifo_pause_d0 & ~fifo_pause_d1;
  assign elig1   = active & ~fifo_empty_vc1 & ~fifo_pause_d0 & ~fifo_pause_d1;
  assign pop0    = (state_q == SERVE_VC0) & elig0;
  assign pop1    = (state_q == SERVE_VC1) & elig1;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wt0_d   = wt0_q;
    wt1_d   = wt1_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        wt0_d = (weight_vc0 == '0) ? {{(WEIGHT_W-1){1'b0}}, 1'b1} : weight_vc0;
        wt1_d = (weight_vc1 == '0) ? {{(WEIGHT_W-1){1'b0}}, 1'b1} : weight_vc1;
        cnt_d = '0;
        if (elig0 && elig1) begin
          state_d = last_q ? SERVE_VC0 : SERVE_VC1;
        end else if (elig0) begin
          state_d = SERVE_VC0;
        end else if (elig1) begin
          state_d = SERVE_VC1;
        end
      end
      SERVE_VC0: begin
        if (pop0) begin
          if (cnt_inc == wt0_q) begin
            cnt_d   = '0;
            last_d  = 1'b0;
            state_d = elig1 ? SERVE_VC1 : IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (fifo_empty_vc0) begin
          cnt_d   = '0;
          state_d = elig1 ? SERVE_VC1 : IDLE;
        end
      end
      SERVE_VC1: begin
        if (pop1) begin
          if (cnt_inc == wt1_q) begin
            cnt_d   = '0;
            last_d  = 1'b1;
            state_d = elig0 ? SERVE_VC0 : IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (fifo_empty_vc1) begin
          cnt_d   = '0;
          state_d = elig0 ? SERVE_VC0 : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Read data arrives the cycle after the pop; the pop/source pair is carried one stage to meet it.
  always_comb begin
    pop_d     = pop0 | pop1;
    src_d     = pop1;
    rd_word   = src_q ? data_mux_1 : data_mux_0;
    push_d0_d = pop_q & ~rd_word[DEST_BIT];
    push_d1_d = pop_q &  rd_word[DEST_BIT];
    data_d0_d = push_d0_d ? rd_word : data_d0_q;
    data_d1_d = push_d1_d ? rd_word : data_d1_q;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wt0_q     <= {{(WEIGHT_W-1){1'b0}}, 1'b1};
      wt1_q     <= {{(WEIGHT_W-1){1'b0}}, 1'b1};
      last_q    <= 1'b1;
      pop_q     <= 1'b0;
      src_q     <= 1'b0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_d0_q <= '0;
      data_d1_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wt0_q     <= wt0_d;
      wt1_q     <= wt1_d;
      last_q    <= last_d;
      pop_q     <= pop_d;
      src_q     <= src_d;
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
      data_d0_q <= data_d0_d;
      data_d1_q <= data_d1_d;
    end
  end

  assign pop_vc0 = pop0;
  assign pop_vc1 = pop1;
  assign push_d0 = push_d0_q;
  assign push_d1 = push_d1_q;
  assign data_d0 = data_d0_q;
  assign data_d1 = data_d1_q;
  assign grant   = state_q;

endmodule
